io_decimal_display: RTL

- Downstream consumer of one 32-bit processor output port (out1/out2/out3 driven by the IO block on OUT instructions).
- Converts the captured binary value to decimal with a sequential double-dabble engine, optionally signed.
- Drives eight active-low 7-segment digits on the board.
- One instance per output port; sits between the processor top level and the board HEX pins.

---
 rtl/io_decimal_display.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/io_decimal_display.sv
// rtl/io_decimal_display.sv - binary to 8-digit 7-segment display via sequential double-dabble
module io_decimal_display #(
  parameter bit BLANK_LEADING  = 1'b1,
  parameter bit SIGNED_DEFAULT = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] value,
  input  logic        load,
  input  logic        signed_mode,
  output logic        busy,
  output logic        overflow,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic [6:0]  hex4,
  output logic [6:0]  hex5,
  output logic [6:0]  hex6,
  output logic [6:0]  hex7
);

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_ZERO  = 7'h40;

  typedef enum logic [1:0] {IDLE, SHIFT, PUBLISH} stateType;

  stateType    state, stateNext;
  logic [31:0] mag;
  logic        neg;
  logic [39:0] bcd;
  logic [4:0]  count;
  logic        pendValid;
  logic [31:0] pendValue;
  logic        pendSigned;
  logic [6:0]  hexReg [8];
  logic [6:0]  pubHex [8];
  logic        pubOverflow;
  logic        startConv;
  logic        consumePend;
  logic        loadDirect;
  logic [31:0] startValue;
  logic        startSigned;
  logic        startNeg;
  logic [31:0] startMag;
  logic        fits;
  logic        seenNonzero;
  logic [3:0]  digit;
  logic        unusedSignedDefault;

  assign unusedSignedDefault = SIGNED_DEFAULT;

  function automatic logic [6:0] segCode(input logic [3:0] d);
    case (d)
      4'd0:    segCode = 7'h40;
      4'd1:    segCode = 7'h79;
      4'd2:    segCode = 7'h24;
      4'd3:    segCode = 7'h30;
      4'd4:    segCode = 7'h19;
      4'd5:    segCode = 7'h12;
      4'd6:    segCode = 7'h02;
      4'd7:    segCode = 7'h78;
      4'd8:    segCode = 7'h00;
      4'd9:    segCode = 7'h10;
      default: segCode = SEG_BLANK;
    endcase
  endfunction

  // One double-dabble step: correct every nibble >= 5, then shift in the next magnitude bit
  function automatic logic [39:0] dabble(input logic [39:0] b, input logic inBit);
    logic [39:0] adj;
    logic [3:0]  nib;
    adj = '0;
    for (int i = 0; i < 10; i++) begin
      nib = b[4*i +: 4];
      if (nib >= 4'd5) nib = nib + 4'd3;
      adj[4*i +: 4] = nib;
    end
    return {adj[38:0], inBit};
  endfunction

  // Next-state and conversion-start decisions; a waiting pending value beats a fresh load at publish
  always_comb begin
    stateNext   = state;
    startConv   = 1'b0;
    consumePend = 1'b0;
    loadDirect  = 1'b0;
    startValue  = value;
    startSigned = signed_mode;
    case (state)
      IDLE: begin
        if (load) begin
          startConv  = 1'b1;
          loadDirect = 1'b1;
          stateNext  = SHIFT;
        end
      end
      SHIFT: begin
        if (count == 5'd31) stateNext = PUBLISH;
      end
      PUBLISH: begin
        if (pendValid) begin
          startConv   = 1'b1;
          consumePend = 1'b1;
          startValue  = pendValue;
          startSigned = pendSigned;
          stateNext   = SHIFT;
        end else if (load) begin
          startConv  = 1'b1;
          loadDirect = 1'b1;
          stateNext  = SHIFT;
        end else begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
    startNeg = startSigned && startValue[31];
    startMag = startNeg ? (~startValue + 32'd1) : startValue;
  end

  // Segment image for the finished BCD value, including fit check and leading-zero blanking
  always_comb begin
    for (int i = 0; i < 8; i++) pubHex[i] = SEG_BLANK;
    fits        = neg ? (bcd[39:28] == 12'd0) : (bcd[39:32] == 8'd0);
    pubOverflow = !fits;
    seenNonzero = 1'b0;
    digit       = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      digit = bcd[4*i +: 4];
      if (!fits || (neg && i == 7)) begin
        pubHex[i] = SEG_DASH;
      end else begin
        seenNonzero = seenNonzero || (digit != 4'd0);
        if (BLANK_LEADING && !seenNonzero && i != 0) pubHex[i] = SEG_BLANK;
        else                                          pubHex[i] = segCode(digit);
      end
    end
  end

  // State register
  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= stateNext;
  end

  // Conversion datapath, pending slot and registered display outputs
  always_ff @(posedge clock) begin
    if (!reset) begin
      mag        <= '0;
      neg        <= 1'b0;
      bcd        <= '0;
      count      <= '0;
      busy       <= 1'b0;
      overflow   <= 1'b0;
      pendValid  <= 1'b0;
      pendValue  <= '0;
      pendSigned <= 1'b0;
      hexReg[0]  <= SEG_ZERO;
      for (int i = 1; i < 8; i++) hexReg[i] <= SEG_BLANK;
    end else begin
      if (startConv) begin
        mag   <= startMag;
        neg   <= startNeg;
        bcd   <= '0;
        count <= '0;
        busy  <= 1'b1;
      end else if (state == SHIFT) begin
        bcd   <= dabble(bcd, mag[31]);
        mag   <= {mag[30:0], 1'b0};
        count <= count + 5'd1;
      end
      if (state == PUBLISH) begin
        for (int i = 0; i < 8; i++) hexReg[i] <= pubHex[i];
        overflow <= pubOverflow;
        if (!startConv) busy <= 1'b0;
      end
      if (load && !loadDirect) begin
        pendValid  <= 1'b1;
        pendValue  <= value;
        pendSigned <= signed_mode;
      end else if (consumePend) begin
        pendValid <= 1'b0;
      end
    end
  end

  assign hex0 = hexReg[0];
  assign hex1 = hexReg[1];
  assign hex2 = hexReg[2];
  assign hex3 = hexReg[3];
  assign hex4 = hexReg[4];
  assign hex5 = hexReg[5];
  assign hex6 = hexReg[6];
  assign hex7 = hexReg[7];

endmodule
